// File: rtl/eeprom_access_arbiter.sv
// Microwire EEPROM port arbiter: sequences READ transactions for the config
// loader and EERD, and passes EECD bit-bang pins through once software is granted.
module eeprom_access_arbiter #(
    parameter int CLK_DIV = 8,
    parameter int CS_LOW  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [7:0]  ld_addr,
    output logic        ld_ready,
    output logic        ld_done,
    output logic [15:0] ld_data,
    input  logic        eerd_start,
    input  logic [7:0]  eerd_addr,
    output logic        eerd_done,
    output logic [15:0] eerd_data,
    input  logic        sw_req,
    output logic        sw_gnt,
    input  logic        sw_sk,
    input  logic        sw_cs,
    input  logic        sw_di,
    output logic        sw_do,
    output logic        ee_sk,
    output logic        ee_cs,
    output logic        ee_di,
    input  logic        ee_do,
    output logic        busy
);

    localparam int CNT_MAX = (CLK_DIV > CS_LOW) ? CLK_DIV : CS_LOW;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(CS_LOW - 1);

    typedef enum logic [2:0] {
        IDLE, RD_START, RD_CMD, RD_DATA, CS_HOLD, SW_OWN
    } state_e;

    typedef enum logic {OWN_LD, OWN_EERD} owner_e;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [10:0]   cmd_q, cmd_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_addr_q, pend_addr_d;
    logic          ld_ready_q, ld_ready_d;
    logic          ld_done_q, ld_done_d;
    logic [15:0]   ld_data_q, ld_data_d;
    logic          eerd_done_q, eerd_done_d;
    logic [15:0]   eerd_data_q, eerd_data_d;
    logic          sw_gnt_q, sw_gnt_d;
    logic          sw_do_q, sw_do_d;
    logic          ee_sk_q, ee_sk_d;
    logic          ee_cs_q, ee_cs_d;
    logic          ee_di_q, ee_di_d;

    logic half_end;
    logic eerd_in_flight;

    assign half_end       = (cnt_q == '0);
    assign eerd_in_flight = (owner_q == OWN_EERD) &&
                            (state_q inside {RD_START, RD_CMD, RD_DATA});

    always_comb begin
        // NOTE: every _d starts from its held value so no path through the case infers a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        cmd_d       = cmd_q;
        rdata_d     = rdata_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        ld_ready_d  = 1'b0;
        ld_done_d   = 1'b0;
        ld_data_d   = ld_data_q;
        eerd_done_d = eerd_done_q;
        eerd_data_d = eerd_data_q;
        sw_gnt_d    = sw_gnt_q;
        sw_do_d     = sw_do_q;
        ee_sk_d     = ee_sk_q;
        ee_cs_d     = ee_cs_q;
        ee_di_d     = ee_di_q;

        case (state_q)
            IDLE: begin
                if (ld_valid || pend_q) begin
                    state_d = RD_START;
                    ee_cs_d = 1'b1;
                    ee_sk_d = 1'b0;
                    ee_di_d = 1'b0;
                    cnt_d   = DIV_LAST;
                    if (ld_valid) begin
                        owner_d    = OWN_LD;
                        cmd_d      = {3'b110, ld_addr};
                        ld_ready_d = 1'b1;
                    end else begin
                        owner_d = OWN_EERD;
                        cmd_d   = {3'b110, pend_addr_q};
                        pend_d  = 1'b0;
                    end
                end else if (sw_req && !eerd_start) begin
                    // A same-edge EERD start outranks the software request.
                    state_d  = SW_OWN;
                    sw_gnt_d = 1'b1;
                end
            end

            RD_START: begin
                if (half_end) begin
                    state_d = RD_CMD;
                    bit_d   = 4'd0;
                    ee_di_d = cmd_q[10];
                    cnt_d   = DIV_LAST;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            RD_CMD, RD_DATA: begin
                if (!half_end) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = DIV_LAST;
                    if (!ee_sk_q) begin
                        ee_sk_d = 1'b1;
                        if (state_q == RD_DATA) begin
                            rdata_d = {rdata_q[14:0], ee_do};
                        end
                    end else begin
                        ee_sk_d = 1'b0;
                        if (state_q == RD_CMD) begin
                            if (bit_q == 4'd10) begin
                                state_d = RD_DATA;
                                bit_d   = 4'd0;
                                ee_di_d = 1'b0;
                            end else begin
                                bit_d   = bit_q + 4'd1;
                                cmd_d   = {cmd_q[9:0], 1'b0};
                                ee_di_d = cmd_q[9];
                            end
                        end else if (bit_q == 4'd15) begin
                            state_d = CS_HOLD;
                            ee_cs_d = 1'b0;
                            ee_di_d = 1'b0;
                            cnt_d   = HOLD_LAST;
                            if (owner_q == OWN_LD) begin
                                ld_data_d = rdata_q;
                                ld_done_d = 1'b1;
                            end else begin
                                eerd_data_d = rdata_q;
                                eerd_done_d = 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end

            CS_HOLD: begin
                if (half_end) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            SW_OWN: begin
                sw_do_d = ee_do;
                if (!sw_req) begin
                    state_d  = CS_HOLD;
                    sw_gnt_d = 1'b0;
                    ee_sk_d  = 1'b0;
                    ee_cs_d  = 1'b0;
                    ee_di_d  = 1'b0;
                    cnt_d    = HOLD_LAST;
                end else begin
                    ee_sk_d = sw_sk;
                    ee_cs_d = sw_cs;
                    ee_di_d = sw_di;
                end
            end

            default: state_d = IDLE;
        endcase

        // A restart while the EERD read is still on the wire is dropped.
        if (eerd_start && !eerd_in_flight) begin
            pend_d      = 1'b1;
            pend_addr_d = eerd_addr;
            eerd_done_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_LD;
            cnt_q       <= '0;
            bit_q       <= '0;
            cmd_q       <= '0;
            rdata_q     <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            ld_ready_q  <= 1'b0;
            ld_done_q   <= 1'b0;
            ld_data_q   <= '0;
            eerd_done_q <= 1'b0;
            eerd_data_q <= '0;
            sw_gnt_q    <= 1'b0;
            sw_do_q     <= 1'b0;
            ee_sk_q     <= 1'b0;
            ee_cs_q     <= 1'b0;
            ee_di_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            cmd_q       <= cmd_d;
            rdata_q     <= rdata_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            ld_ready_q  <= ld_ready_d;
            ld_done_q   <= ld_done_d;
            ld_data_q   <= ld_data_d;
            eerd_done_q <= eerd_done_d;
            eerd_data_q <= eerd_data_d;
            sw_gnt_q    <= sw_gnt_d;
            sw_do_q     <= sw_do_d;
            ee_sk_q     <= ee_sk_d;
            ee_cs_q     <= ee_cs_d;
            ee_di_q     <= ee_di_d;
        end
    end

    assign ld_ready  = ld_ready_q;
    assign ld_done   = ld_done_q;
    assign ld_data   = ld_data_q;
    assign eerd_done = eerd_done_q;
    assign eerd_data = eerd_data_q;
    assign sw_gnt    = sw_gnt_q;
    assign sw_do     = sw_do_q;
    assign ee_sk     = ee_sk_q;
    assign ee_cs     = ee_cs_q;
    assign ee_di     = ee_di_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/eeprom_access_arbiter.md
Name: eeprom_access_arbiter

Overview:
Owns the serial Microwire EEPROM port and shares it between three requesters: the power-on config loader (ld_*), the EERD auto-read register (eerd_*), and the EECD software bit-bang path (sw_*). For loader and EERD requests it sequences a full READ transaction (start, opcode 10, 8-bit address, 16 data bits) itself. For software it passes EECD pins through after the EE_REQ/EE_GNT handshake. It sits between e1000_regs and the EEPROM pins, replacing ad-hoc muxing of EECD and EERD traffic.

Parameters:
CLK_DIV, 8, clk cycles per sk half-period (>=1)
CS_LOW, 4, minimum clk cycles cs held low after any transaction or release (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
ld_valid  in  1  loader read request (level, held until ld_ready)
ld_addr  in  8  loader word address
ld_ready  out  1  1-cycle pulse: loader request accepted
ld_done  out  1  1-cycle pulse: ld_data valid
ld_data  out  16  loader read data
eerd_start  in  1  1-cycle pulse: EERD.START write
eerd_addr  in  8  EERD.ADDR, sampled with eerd_start
eerd_done  out  1  EERD.DONE status (sticky)
eerd_data  out  16  EERD.DATA
sw_req  in  1  EECD.EE_REQ (level)
sw_gnt  out  1  EECD.EE_GNT
sw_sk  in  1  EECD.SK
sw_cs  in  1  EECD.CS
sw_di  in  1  EECD.DI
sw_do  out  1  EECD.DO (registered ee_do)
ee_sk  out  1  EEPROM serial clock
ee_cs  out  1  EEPROM chip select
ee_di  out  1  EEPROM data in
ee_do  in  1  EEPROM data out
busy  out  1  arbiter not IDLE

Behaviour:
- Reset values: all outputs 0; eerd_pend=0; state IDLE.
- eerd_start latches eerd_addr into a pending slot, sets eerd_pend and clears eerd_done on the next edge. If an EERD transaction is already in flight, the start is ignored and eerd_done is left unchanged.
- IDLE arbitration uses fixed priority, loader > EERD pending > software. It is non-preemptive: a requester keeps ownership until it completes or releases.
- IDLE -> RD_START on ld_valid (ld_ready pulses the same cycle, address latched) or on eerd_pend (pend cleared). IDLE -> SW_OWN on sw_req when no other request is present.
- RD_START: cs=1, sk=0, di=0 for CLK_DIV cycles.
- RD_CMD: 11 bits shifted MSB-first: 1, 1, 0, A7..A0. Each bit has sk low for CLK_DIV cycles, then sk high for CLK_DIV cycles. di changes only on the cycle sk falls or on bit entry.
- RD_DATA: 16 bits with the same timing. ee_do is sampled on the clk edge where sk rises and shifted in MSB-first.
- After the last data half-period, go to CS_HOLD: cs=0, sk=0, di=0 for CS_LOW cycles, then IDLE. On entry to CS_HOLD:
  - loader owner: ld_data updated, ld_done pulses.
  - EERD owner: eerd_data updated, eerd_done set.
- Latency from accept edge to result = 1 + CLK_DIV + 54*CLK_DIV cycles (CLK_DIV=2 gives 111).
- SW_OWN: sw_gnt=1. ee_sk/ee_cs/ee_di are registered copies of sw_sk/sw_cs/sw_di (1-cycle latency). sw_do is a registered ee_do.
  - sw_req low: sw_gnt drops next edge, go to CS_HOLD.
  - A loader or EERD request arriving in SW_OWN waits.
- Outside SW_OWN, sw_* pin inputs have no effect. sw_do holds its last value.
- busy = (state != IDLE).
- Asynchronous rst mid-transaction: immediately returns all outputs to 0 and discards pending and latched requests.
- sw_req asserted at the same edge as eerd_start: EERD wins.

Test Plan:
- EEPROM model word 0x01=0xABCD, CLK_DIV=2: pulse eerd_start, addr 0x01 -> ee_di command bits 1,1,0,0000_0001; eerd_done rises exactly 111 cycles after accept; eerd_data=0xABCD; cs low 4 cycles afterwards.
- ld_valid addr 0xFF (word 0x1234) and eerd_start addr 0x00 in the same cycle -> loader served first (ld_done, ld_data=0x1234); EERD follows after CS_HOLD, eerd_data=word0.
- sw_req=1 while idle -> sw_gnt=1 after 1 cycle. Toggle sw_sk/cs/di through 6 combinations -> ee_* follow with 1-cycle delay; sw_do tracks ee_do. Drop sw_req -> sw_gnt=0, ee_cs=0 for 4 cycles.
- eerd_start during SW_OWN -> no ee_* activity until release; then read completes and eerd_done=1.
- Second eerd_start mid-read -> ignored; first read's data reported; eerd_done not cleared.
- rst pulse during RD_DATA -> ee_cs/sk/di=0, busy=0, eerd_pend=0 immediately; a later eerd_start works normally.
